// File: rtl/vx_axi_pkg.sv
// Shared AXI definitions for the vx_axi issue blocks: burst/response codes,
// write-channel state encoding and the AxSIZE helper.
package vx_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Encoding is {aw_pend, w_pend} so each bit maps straight onto a valid.
    typedef enum logic [1:0] {
        CH_IDLE    = 2'b00,
        CH_W_ONLY  = 2'b01,
        CH_AW_ONLY = 2'b10,
        CH_BOTH    = 2'b11
    } ch_state_e;

    // AxSIZE for a beat of nbytes bytes (nbytes is a power of two up to 128).
    function automatic logic [2:0] axi_size(input int unsigned nbytes);
        logic [2:0] sz;
        sz = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (nbytes == (32'd1 << i)) sz = 3'(i);
        end
        return sz;
    endfunction

endpackage

// File: rtl/vx_axi_rsp_reg.sv
// One-entry valid/ready output register. Accepts a new beat whenever the
// slot is empty or is being drained in the same cycle, so it sustains one
// beat per cycle when the consumer is always ready.
module vx_axi_rsp_reg #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Load on an incoming beat, otherwise empty the slot once it is consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/vx_axi_write_issue.sv
// Converts single-beat core write requests into AXI4 AW/W beats, bounds the
// number of outstanding writes with a credit counter, and turns B responses
// into tagged completions.
module vx_axi_write_issue
    import vx_axi_pkg::*;
#(
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 26,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TAG_WIDTH      = 8,
    parameter int MAX_PENDING    = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [DATA_WIDTH-1:0]           req_data,
    input  logic [DATA_WIDTH/8-1:0]         req_byteen,
    input  logic [TAG_WIDTH-1:0]            req_tag,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]       m_axi_awaddr,
    output logic [TAG_WIDTH-1:0]            m_axi_awid,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic [1:0]                      m_axi_awlock,
    output logic [3:0]                      m_axi_awcache,
    output logic [2:0]                      m_axi_awprot,
    output logic [3:0]                      m_axi_awqos,
    output logic [3:0]                      m_axi_awregion,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    output logic [DATA_WIDTH-1:0]           m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]         m_axi_wstrb,
    output logic                            m_axi_wlast,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    input  logic [TAG_WIDTH-1:0]            m_axi_bid,
    input  logic [1:0]                      m_axi_bresp,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [TAG_WIDTH-1:0]            rsp_tag,
    output logic                            rsp_err,
    output logic                            err_sticky,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending_cnt
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam int OFFS  = $clog2(DATA_WIDTH / 8);

    ch_state_e                 ch_state;
    logic                      aw_pend, w_pend;
    logic                      aw_fire, w_fire, b_fire, req_fire;
    logic [AXI_ADDR_WIDTH-1:0] byte_addr;
    logic [TAG_WIDTH:0]        rsp_word;

    assign aw_pend = (ch_state == CH_BOTH) || (ch_state == CH_AW_ONLY);
    assign w_pend  = (ch_state == CH_BOTH) || (ch_state == CH_W_ONLY);

    assign m_axi_awvalid = aw_pend;
    assign m_axi_wvalid  = w_pend;

    assign aw_fire  = m_axi_awvalid && m_axi_awready;
    assign w_fire   = m_axi_wvalid && m_axi_wready;
    assign b_fire   = m_axi_bvalid && m_axi_bready;
    assign req_fire = req_valid && req_ready;

    // A new request may overwrite a channel register only in the cycle it drains.
    assign req_ready = (!aw_pend || aw_fire) && (!w_pend || w_fire)
                       && (pending_cnt < CNT_W'(MAX_PENDING));

    assign byte_addr = AXI_ADDR_WIDTH'(req_addr) << OFFS;

    assign m_axi_awlen    = 8'd0;
    assign m_axi_awsize   = axi_size(DATA_WIDTH / 8);
    assign m_axi_awburst  = AXI_BURST_INCR;
    assign m_axi_awlock   = 2'b00;
    assign m_axi_awcache  = 4'b0000;
    assign m_axi_awprot   = 3'b000;
    assign m_axi_awqos    = 4'b0000;
    assign m_axi_awregion = 4'b0000;
    assign m_axi_wlast    = 1'b1;

    // Channel FSM: a request reloads both channels, each channel drains on its own fire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_state     <= CH_IDLE;
            m_axi_awaddr <= '0;
            m_axi_awid   <= '0;
            m_axi_wdata  <= '0;
            m_axi_wstrb  <= '0;
        end else if (req_fire) begin
            ch_state     <= CH_BOTH;
            m_axi_awaddr <= byte_addr;
            m_axi_awid   <= req_tag;
            m_axi_wdata  <= req_data;
            m_axi_wstrb  <= req_byteen;
        end else begin
            case (ch_state)
                CH_BOTH: begin
                    if (aw_fire && w_fire) ch_state <= CH_IDLE;
                    else if (aw_fire)      ch_state <= CH_W_ONLY;
                    else if (w_fire)       ch_state <= CH_AW_ONLY;
                end
                CH_AW_ONLY: if (aw_fire) ch_state <= CH_IDLE;
                CH_W_ONLY:  if (w_fire)  ch_state <= CH_IDLE;
                default: ;
            endcase
        end
    end

    // Outstanding-write credits and the sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_cnt <= '0;
            err_sticky  <= 1'b0;
        end else begin
            case ({req_fire, b_fire})
                2'b10:   pending_cnt <= pending_cnt + CNT_W'(1);
                2'b01:   pending_cnt <= pending_cnt - CNT_W'(1);
                default: ;
            endcase
            if (b_fire && (m_axi_bresp != AXI_RESP_OKAY)) err_sticky <= 1'b1;
        end
    end

    // A B beat with no outstanding write means the interconnect invented a response.
    assert property (@(posedge clk) disable iff (!reset) b_fire |-> (pending_cnt != '0));

    vx_axi_rsp_reg #(
        .WIDTH (TAG_WIDTH + 1)
    ) u_rsp_reg (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (m_axi_bvalid),
        .in_ready  (m_axi_bready),
        .in_data   ({m_axi_bid, (m_axi_bresp != AXI_RESP_OKAY)}),
        .out_valid (rsp_valid),
        .out_ready (rsp_ready),
        .out_data  (rsp_word)
    );

    assign rsp_tag = rsp_word[TAG_WIDTH:1];
    assign rsp_err = rsp_word[0];

endmodule

// File: doc/vx_axi_write_issue.md
Name: vx_axi_write_issue

Overview:
- Upstream feeder for the AXI write-channel arbiter: converts single-beat write requests from a core-side memory port into AXI4 AW and W channels, then returns B responses as tagged completions.
- AW and W are issued independently, so AXI ordering freedom between the address and data channels is preserved.
- Outstanding writes are bounded by a credit counter.
- One instance sits in front of each arbiter input slave.

Parameters:
- DATA_WIDTH, 512, write data bits per beat; must be a power of 2 and at least 8.
- ADDR_WIDTH, 26, request address in DATA_WIDTH-sized words.
- AXI_ADDR_WIDTH, 32, AXI byte address width; must be at least ADDR_WIDTH + log2(DATA_WIDTH/8).
- TAG_WIDTH, 8, request tag width; this is also the AXI ID width.
- MAX_PENDING, 16, maximum writes with AW issued but B not yet returned; must be at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_valid  in  1  write request valid
- req_ready  out  1  write request accepted
- req_addr  in  ADDR_WIDTH  word address
- req_data  in  DATA_WIDTH  write data
- req_byteen  in  DATA_WIDTH/8  byte enables
- req_tag  in  TAG_WIDTH  request tag
- m_axi_awvalid/awready  out/in  1  AW handshake
- m_axi_awaddr  out  AXI_ADDR_WIDTH  byte address
- m_axi_awid  out  TAG_WIDTH  equals the request tag
- m_axi_awlen  out  8  constant 0
- m_axi_awsize  out  3  log2(DATA_WIDTH/8)
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_awlock, awcache, awprot, awqos, awregion  out  2/4/3/4/4  constant 0
- m_axi_wvalid/wready  out/in  1  W handshake
- m_axi_wdata  out  DATA_WIDTH  write data
- m_axi_wstrb  out  DATA_WIDTH/8  byte strobes
- m_axi_wlast  out  1  constant 1
- m_axi_bvalid/bready  in/out  1  B handshake
- m_axi_bid  in  TAG_WIDTH  response ID
- m_axi_bresp  in  2  response code
- rsp_valid/rsp_ready  out/in  1  completion handshake
- rsp_tag  out  TAG_WIDTH  completed tag
- rsp_err  out  1  completion had bresp != OKAY
- err_sticky  out  1  latched on any non-OKAY response; cleared only by reset
- pending_cnt  out  $clog2(MAX_PENDING+1)  number of outstanding writes

Behaviour:
- Reset (reset=0, asynchronous): awvalid=0, wvalid=0, rsp_valid=0, rsp_err=0, err_sticky=0, pending_cnt=0. All payload registers are cleared to 0.
- Channel state is held in two flags, aw_pend and w_pend, giving four states:
  - IDLE (0,0)
  - BOTH (1,1)
  - AW_ONLY (1,0)
  - W_ONLY (0,1)
- Output mapping: awvalid=aw_pend and wvalid=w_pend.
- Fire events: aw_fire = awvalid & awready, w_fire = wvalid & wready, b_fire = bvalid & bready, req_fire = req_valid & req_ready.
- req_ready = (!aw_pend | aw_fire) & (!w_pend | w_fire) & (pending_cnt < MAX_PENDING). This is combinational and permits one request per cycle at full throughput.
- On req_fire, registered with 1-cycle latency to valid:
  - awaddr = {req_addr, log2(DATA_WIDTH/8) zero bits}, zero-extended to AXI_ADDR_WIDTH.
  - awid = req_tag; wdata = req_data; wstrb = req_byteen.
  - Both flags are set.
- AW and W payloads are held stable while their valid is high.
- Each flag clears independently on its own fire, unless a req_fire in the same cycle reloads it.
- Transitions:
  - BOTH goes to W_ONLY on aw_fire alone, to AW_ONLY on w_fire alone, and to IDLE on both fires.
  - AW_ONLY goes to IDLE on aw_fire.
  - W_ONLY goes to IDLE on w_fire.
  - Any state goes to BOTH on req_fire.
- pending_cnt: +1 on req_fire, -1 on b_fire, unchanged when both occur in the same cycle.
  - b_fire while pending_cnt==0 is a protocol violation and must trigger an assertion.
  - The counter saturates logically because req_ready=0 at MAX_PENDING.
- Response path is a 1-entry output register:
  - bready = !rsp_valid | rsp_ready.
  - On b_fire: rsp_valid=1, rsp_tag=bid, rsp_err=(bresp!=0).
  - rsp_valid clears on rsp_ready when no new b_fire occurs in the same cycle.
  - Back-to-back B beats pass at one per cycle when rsp_ready is held high.
- err_sticky is set on any b_fire with bresp!=0.
- bid is passed through unmodified; ordering among responses is whatever order the interconnect returns.
- Mid-operation reset drops all in-flight AW, W and response state without generating responses. The environment must also reset the downstream interconnect.

Decomposition:
- Shared package vx_axi_pkg holds:
  - AXI_BURST_INCR, AXI_RESP_OKAY, AXI_RESP_SLVERR, AXI_RESP_DECERR.
  - A function computing awsize from a byte count.
- Sub-module vx_axi_rsp_reg implements the 1-entry valid/ready response register (TAG_WIDTH+1 payload). It is reusable by a future read-issue block.

Test Plan:
- Single write with awready=wready=1 always; req addr=0x10, tag=0x5A, byteen=all ones:
  - awvalid and wvalid assert the cycle after acceptance.
  - awaddr=0x400 for DATA_WIDTH=512; awsize=6; awlen=0; wlast=1.
  - bid=0x5A returned → rsp_tag=0x5A, rsp_err=0, pending_cnt returns to 0.
- Decoupled channels: awready=1, wready held 0 for 3 cycles:
  - State goes BOTH → W_ONLY; req_ready=0 until the w_fire cycle.
  - A second request is accepted in the same cycle as w_fire.
- Credit limit with MAX_PENDING=4: issue 5 requests with B withheld:
  - req_ready drops after the 4th; pending_cnt=4.
  - One b_fire → 5th request accepted; simultaneous req_fire+b_fire keeps the count at 4.
- Error response bresp=2'b10, tag 0x03:
  - rsp_err=1 and err_sticky=1.
  - A following OKAY response gives rsp_err=0 with err_sticky still 1.
- Response backpressure: rsp_ready=0 while two B beats arrive:
  - bready=0 after the first; the second bid is held by the interconnect.
  - Raising rsp_ready delivers both tags in order over 2 cycles.
- Assert reset low while the block is in the BOTH state with pending_cnt=3:
  - All valids drop asynchronously, pending_cnt=0, err_sticky=0.
  - After release, the first request behaves as in the first scenario.
